// File: rtl/tl45_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tl45_pkg : opcode, condition-code, flags and FSM types for tl45     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package tl45_pkg;

  typedef enum logic [4:0] {
    OP_NOP = 5'h00,
    OP_ADD = 5'h01,
    OP_SUB = 5'h02,
    OP_MUL = 5'h03,
    OP_AND = 5'h06,
    OP_OR  = 5'h07,
    OP_XOR = 5'h08,
    OP_NOT = 5'h09,
    OP_SHL = 5'h0A,
    OP_SHR = 5'h0B,
    OP_JMP = 5'h0C,
    OP_LW  = 5'h15,
    OP_SW  = 5'h16
  } opcode_e;

  typedef enum logic [3:0] {
    CC_ALWAYS = 4'd0,
    CC_Z      = 4'd1,
    CC_NZ     = 4'd2,
    CC_N      = 4'd3,
    CC_NN     = 4'd4,
    CC_C      = 4'd5,
    CC_NC     = 4'd6,
    CC_V      = 4'd7,
    CC_NV     = 4'd8,
    CC_LT     = 4'd9,
    CC_GE     = 4'd10
  } cond_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mul_state_e;

  // Single-cycle ALU ops: these write a register and update FLAGS.
  function automatic logic is_alu(input logic [4:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic cond_met(input logic [3:0] cond, input flags_t f);
    logic r;
    r = 1'b0;
    case (cond)
      CC_ALWAYS: r = 1'b1;
      CC_Z:      r = f.z;
      CC_NZ:     r = !f.z;
      CC_N:      r = f.n;
      CC_NN:     r = !f.n;
      CC_C:      r = f.c;
      CC_NC:     r = !f.c;
      CC_V:      r = f.v;
      CC_NV:     r = !f.v;
      CC_LT:     r = f.n ^ f.v;
      CC_GE:     r = !(f.n ^ f.v);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl45_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tl45_multiplier : iterative shift-add multiplier, low 32 bits kept  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tl45_multiplier
  import tl45_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_abort,
  input  logic        i_start,
  input  logic        i_ack,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  mul_state_e      r_state;
  mul_state_e      w_next;
  logic [31:0]     r_acc;
  logic [31:0]     r_mcand;
  logic [31:0]     r_mplier;
  logic [CW-1:0]   r_count;
  logic            w_last;

  assign w_last    = (r_count == CW'(MUL_CYCLES - 1));
  assign o_busy    = (r_state == MS_BUSY);
  assign o_done    = (r_state == MS_DONE);
  assign o_product = r_acc;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_abort) begin
      r_state <= MS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MS_IDLE: if (i_start) w_next = MS_BUSY;
      MS_BUSY: if (w_last)  w_next = MS_DONE;
      MS_DONE: if (i_ack)   w_next = MS_IDLE;
      default: w_next = MS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_abort) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (r_state == MS_IDLE && i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_count  <= '0;
    end else if (r_state == MS_BUSY) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tl45_execute.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tl45_execute : execute stage - ALU, FLAGS, JMP resolve, MUL, fwd   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tl45_execute
  import tl45_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  output logic        o_pipe_stall,
  input  logic        i_pipe_flush,
  output logic        o_pipe_flush,
  input  logic [4:0]  i_opcode,
  input  logic [3:0]  i_dr,
  input  logic [31:0] i_sr1_val,
  input  logic [31:0] i_sr2_val,
  input  logic [31:0] i_target_offset,
  input  logic [31:0] i_pc,
  output logic        o_branch_taken,
  output logic [31:0] o_branch_target,
  output logic [3:0]  o_of1_reg,
  output logic [31:0] o_of1_data,
  output logic [3:0]  o_of2_reg,
  output logic [31:0] o_of2_data,
  output logic [4:0]  o_opcode,
  output logic [3:0]  o_dr,
  output logic [31:0] o_value,
  output logic [31:0] o_pc,
  output logic [3:0]  o_flags
);

  flags_t      r_flags;
  flags_t      w_new_flags;
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic [31:0] w_result;
  logic [3:0]  w_dest;
  logic        w_carry;
  logic        w_ovf;
  logic        w_alu_op;
  logic        w_load;
  logic        w_mul_start;
  logic        w_mul_busy;
  logic        w_mul_done;
  logic [31:0] w_mul_product;

  tl45_multiplier #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_abort   (i_pipe_flush),
    .i_start   (w_mul_start),
    .i_ack     (w_load),
    .i_a       (i_sr1_val),
    .i_b       (i_sr2_val),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  assign o_pipe_stall    = i_pipe_stall | w_mul_busy;
  assign w_load          = !o_pipe_stall && !i_pipe_flush;
  // A MUL in DONE is still the held instruction at the input; don't restart it.
  assign w_mul_start     = (i_opcode == OP_MUL) && !w_mul_busy && !w_mul_done
                           && !i_pipe_stall && !i_pipe_flush;
  assign w_alu_op        = is_alu(i_opcode);

  assign o_branch_target = i_sr1_val + i_target_offset;
  assign o_branch_taken  = (i_opcode == OP_JMP) && cond_met(i_dr, r_flags)
                           && !i_pipe_flush && !i_pipe_stall && !i_reset;
  assign o_pipe_flush    = i_pipe_flush | o_branch_taken;

  assign o_of1_reg  = (w_alu_op || ((i_opcode == OP_MUL) && w_mul_done)) ? i_dr : 4'd0;
  assign o_of1_data = w_result;
  assign o_of2_reg  = o_dr;
  assign o_of2_data = o_value;
  assign o_flags    = r_flags;

  always_comb begin
    w_sum    = {1'b0, i_sr1_val} + {1'b0, i_sr2_val};
    w_diff   = {1'b0, i_sr1_val} - {1'b0, i_sr2_val};
    w_result = '0;
    w_dest   = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_result = w_sum[31:0];
        w_carry  = w_sum[32];
        w_ovf    = (i_sr1_val[31] == i_sr2_val[31]) && (w_sum[31] != i_sr1_val[31]);
      end
      OP_SUB: begin
        w_result = w_diff[31:0];
        w_carry  = w_diff[32];
        w_ovf    = (i_sr1_val[31] != i_sr2_val[31]) && (w_diff[31] != i_sr1_val[31]);
      end
      OP_AND:        w_result = i_sr1_val & i_sr2_val;
      OP_OR:         w_result = i_sr1_val | i_sr2_val;
      OP_XOR:        w_result = i_sr1_val ^ i_sr2_val;
      OP_NOT:        w_result = ~i_sr1_val;
      OP_SHL:        w_result = i_sr1_val << i_sr2_val[4:0];
      OP_SHR:        w_result = i_sr1_val >> i_sr2_val[4:0];
      OP_MUL:        w_result = w_mul_product;
      OP_LW, OP_SW:  w_result = o_branch_target;
      OP_JMP:        w_result = o_branch_target;
      default:       w_result = '0;
    endcase
    if (w_alu_op || i_opcode == OP_MUL || i_opcode == OP_LW || i_opcode == OP_SW) begin
      w_dest = i_dr;
    end
    w_new_flags.z = (w_result == '0);
    w_new_flags.n = w_result[31];
    w_new_flags.c = w_carry;
    w_new_flags.v = w_ovf;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_opcode <= '0;
      o_dr     <= '0;
      o_value  <= '0;
      o_pc     <= '0;
      r_flags  <= '0;
    end else if (i_pipe_flush) begin
      o_opcode <= '0;
      o_dr     <= '0;
      o_value  <= '0;
      o_pc     <= '0;
    end else if (w_load) begin
      // A starting MUL leaves a bubble behind it until its product is ready.
      if (w_mul_start) begin
        o_opcode <= '0;
        o_dr     <= '0;
        o_value  <= '0;
        o_pc     <= '0;
      end else begin
        o_opcode <= i_opcode;
        o_dr     <= w_dest;
        o_value  <= w_result;
        o_pc     <= i_pc;
        if (w_alu_op) r_flags <= w_new_flags;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl45_execute.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tl45_execute : self-checking bench with a behavioural model      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_tl45_execute;
  import tl45_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_pipe_stall = 1'b0;
  logic        i_pipe_flush = 1'b0;
  logic [4:0]  i_opcode = '0;
  logic [3:0]  i_dr = '0;
  logic [31:0] i_sr1_val = '0, i_sr2_val = '0, i_target_offset = '0, i_pc = '0;
  logic        o_pipe_stall, o_pipe_flush, o_branch_taken;
  logic [31:0] o_branch_target, o_of1_data, o_of2_data, o_value, o_pc;
  logic [3:0]  o_of1_reg, o_of2_reg, o_dr, o_flags;
  logic [4:0]  o_opcode;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  m_flags = '0;
  logic [4:0]  ops [11];

  always #5 clk = ~clk;

  tl45_execute #(.MUL_CYCLES(32)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_pipe_stall(i_pipe_stall), .o_pipe_stall(o_pipe_stall),
    .i_pipe_flush(i_pipe_flush), .o_pipe_flush(o_pipe_flush),
    .i_opcode(i_opcode), .i_dr(i_dr), .i_sr1_val(i_sr1_val), .i_sr2_val(i_sr2_val),
    .i_target_offset(i_target_offset), .i_pc(i_pc),
    .o_branch_taken(o_branch_taken), .o_branch_target(o_branch_target),
    .o_of1_reg(o_of1_reg), .o_of1_data(o_of1_data),
    .o_of2_reg(o_of2_reg), .o_of2_data(o_of2_data),
    .o_opcode(o_opcode), .o_dr(o_dr), .o_value(o_value), .o_pc(o_pc), .o_flags(o_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] dr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] off, input logic [31:0] pc);
    i_opcode = op; i_dr = dr; i_sr1_val = a; i_sr2_val = b; i_target_offset = off; i_pc = pc;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000 | $urandom_range(0, 3);
      3: return 32'h7FFF_FFFF - $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  // Reference: full-width arithmetic, carry/overflow from range checks.
  function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] off, input logic [3:0] fl_in,
                                 output logic [31:0] res, output logic [3:0] fl_out,
                                 output logic fwd);
    longint sa, sb, ss;
    logic   c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; fwd = 1'b1; res = '0; ss = 0;
    case (op)
      OP_ADD: begin
        res = a + b;
        c   = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        ss  = sa + sb;
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      OP_SUB: begin
        res = a - b;
        c   = a < b;
        ss  = sa - sb;
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: res = a << (b % 32);
      OP_SHR: res = a >> (b % 32);
      OP_LW, OP_SW: begin res = a + off; fwd = 1'b0; end
      default: begin res = '0; fwd = 1'b0; end
    endcase
    if (fwd) fl_out = {res == 0, res[31], c, v};
    else     fl_out = fl_in;
  endfunction

  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] fl);
    logic z, n, c, v;
    {z, n, c, v} = fl;
    case (cc)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return n;
      4'd4: return !n;
      4'd5: return c;
      4'd6: return !c;
      4'd7: return v;
      4'd8: return !v;
      4'd9: return n != v;
      4'd10: return n == v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive(OP_NOP, 0, 0, 0, 0, 0);
    tick(); tick();
    checks++;
    if ({o_opcode, o_dr, o_value, o_pc, o_flags, o_pipe_stall, o_pipe_flush} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got op=%h dr=%h val=%h pc=%h fl=%h st=%b fl=%b, required all 0",
               o_opcode, o_dr, o_value, o_pc, o_flags, o_pipe_stall, o_pipe_flush);
    end
    rst = 1'b0;
    m_flags = '0;
  endtask

  task automatic test_add_overflow();
    drive(OP_ADD, 4'd3, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h40);
    #1;
    checks++;
    if ({o_of1_reg, o_of1_data} !== {4'd3, 32'h8000_0000}) begin
      errors++;
      $display("FAIL add_of1: got reg=%0d data=%h, required reg=3 data=80000000", o_of1_reg, o_of1_data);
    end
    tick();
    checks++;
    if ({o_opcode, o_dr, o_value, o_pc, o_flags} !== {OP_ADD, 4'd3, 32'h8000_0000, 32'h40, 4'b0101}) begin
      errors++;
      $display("FAIL add_buffer: got op=%h dr=%0d val=%h pc=%h flags=%b, required 01 3 80000000 40 0101",
               o_opcode, o_dr, o_value, o_pc, o_flags);
    end
    checks++;
    if ({o_of2_reg, o_of2_data} !== {4'd3, 32'h8000_0000}) begin
      errors++;
      $display("FAIL add_of2: got reg=%0d data=%h, required 3 80000000", o_of2_reg, o_of2_data);
    end
    m_flags = 4'b0101;
  endtask

  task automatic test_jmp_taken();
    drive(OP_SUB, 4'd2, 32'd5, 32'd5, 0, 32'h44);
    tick();
    m_flags = 4'b1000;
    checks++;
    if ({o_value, o_flags} !== {32'd0, 4'b1000}) begin
      errors++;
      $display("FAIL sub_zero: got val=%h flags=%b, required 0 1000", o_value, o_flags);
    end
    i_pipe_stall = 1'b1;
    drive(OP_JMP, 4'd1, 32'h100, 32'h0, 32'h20, 32'h48);
    #1;
    checks++;
    if ({o_branch_taken, o_pipe_flush} !== 2'b00) begin
      errors++;
      $display("FAIL jmp_stalled: got taken=%b flush=%b, required 0 0", o_branch_taken, o_pipe_flush);
    end
    i_pipe_stall = 1'b0;
    #1;
    checks++;
    if ({o_branch_taken, o_pipe_flush, o_branch_target, o_of1_reg} !== {2'b11, 32'h120, 4'd0}) begin
      errors++;
      $display("FAIL jmp_taken: got taken=%b flush=%b target=%h of1=%0d, required 1 1 120 0",
               o_branch_taken, o_pipe_flush, o_branch_target, o_of1_reg);
    end
    tick();
    drive(OP_NOP, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({o_pipe_flush, o_opcode, o_dr, o_flags} !== {1'b0, OP_JMP, 4'd0, 4'b1000}) begin
      errors++;
      $display("FAIL jmp_after: got flush=%b op=%h dr=%0d flags=%b, required 0 0c 0 1000",
               o_pipe_flush, o_opcode, o_dr, o_flags);
    end
  endtask

  task automatic test_random_alu(input int n);
    logic [31:0] a, b, off, pc, res;
    logic [3:0]  dr, fl;
    logic [4:0]  op;
    logic        fwd;
    for (int i = 0; i < n; i++) begin
      op = ops[$urandom_range(0, 10)];
      dr = 4'($urandom_range(1, 15));
      a = rnd32(); b = rnd32(); off = $urandom; pc = $urandom;
      drive(op, dr, a, b, off, pc);
      ref_op(op, a, b, off, m_flags, res, fl, fwd);
      #1;
      checks++;
      if (fwd ? ({o_of1_reg, o_of1_data} !== {dr, res}) : (o_of1_reg !== 4'd0)) begin
        errors++;
        $display("FAIL rand_of1[%0d] op=%h: got reg=%0d data=%h, required reg=%0d data=%h",
                 i, op, o_of1_reg, o_of1_data, fwd ? dr : 4'd0, res);
      end
      tick();
      checks++;
      if ({o_opcode, o_dr, o_value, o_pc, o_flags} !== {op, (op == OP_NOP) ? 4'd0 : dr, res, pc, fl}) begin
        errors++;
        $display("FAIL rand_buf[%0d] op=%h a=%h b=%h: got dr=%0d val=%h pc=%h fl=%b, required dr=%0d val=%h pc=%h fl=%b",
                 i, op, a, b, o_dr, o_value, o_pc, o_flags, (op == OP_NOP) ? 4'd0 : dr, res, pc, fl);
      end
      m_flags = fl;
    end
  endtask

  task automatic test_random_jmp(input int n);
    logic [31:0] a, off, res;
    logic [3:0]  cc, fl;
    logic        fwd, exp_t;
    for (int i = 0; i < n; i++) begin
      a = rnd32();
      drive(ops[$urandom_range(0, 7)], 4'd1, a, rnd32(), 0, 0);
      ref_op(i_opcode, a, i_sr2_val, 0, m_flags, res, fl, fwd);
      tick();
      m_flags = fl;
      cc = 4'($urandom_range(0, 15));
      a = $urandom; off = $urandom;
      drive(OP_JMP, cc, a, 0, off, 0);
      exp_t = ref_cond(cc, m_flags);
      #1;
      checks++;
      if ({o_branch_taken, o_pipe_flush, o_branch_target, o_of1_reg} !== {exp_t, exp_t, a + off, 4'd0}) begin
        errors++;
        $display("FAIL rand_jmp[%0d] cc=%0d flags=%b: got taken=%b flush=%b target=%h of1=%0d, required %b %b %h 0",
                 i, cc, m_flags, o_branch_taken, o_pipe_flush, o_branch_target, o_of1_reg, exp_t, exp_t, a + off);
      end
      tick();
    end
    drive(OP_NOP, 0, 0, 0, 0, 0);
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] dr);
    int   busy_cycles;
    logic bad_of1;
    busy_cycles = 0;
    bad_of1 = 1'b0;
    drive(OP_MUL, dr, a, b, 0, 32'h80);
    tick();
    while (o_pipe_stall && busy_cycles < 40) begin
      if (o_of1_reg !== 4'd0) bad_of1 = 1'b1;
      busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != 32 || bad_of1) begin
      errors++;
      $display("FAIL mul_busy: got %0d stall cycles (of1 nonzero=%b), required 32 (0)", busy_cycles, bad_of1);
    end
    checks++;
    if ({o_of1_reg, o_of1_data} !== {dr, a * b}) begin
      errors++;
      $display("FAIL mul_of1: got reg=%0d data=%h, required reg=%0d data=%h", o_of1_reg, o_of1_data, dr, a * b);
    end
    tick();
    drive(OP_NOP, 0, 0, 0, 0, 0);
    checks++;
    if ({o_opcode, o_dr, o_value, o_flags} !== {OP_MUL, dr, a * b, m_flags}) begin
      errors++;
      $display("FAIL mul_result %h*%h: got op=%h dr=%0d val=%h fl=%b, required 03 %0d %h %b",
               a, b, o_opcode, o_dr, o_value, o_flags, dr, a * b, m_flags);
    end
  endtask

  task automatic test_mul_flush();
    drive(OP_MUL, 4'd7, 32'd123, 32'd456, 0, 32'h90);
    tick();
    repeat (9) tick();
    i_pipe_flush = 1'b1;
    #1;
    checks++;
    if ({o_pipe_flush, o_pipe_stall} !== 2'b11) begin
      errors++;
      $display("FAIL mul_flush_during: got flush=%b stall=%b, required 1 1", o_pipe_flush, o_pipe_stall);
    end
    tick();
    i_pipe_flush = 1'b0;
    drive(OP_NOP, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({o_pipe_stall, o_opcode, o_dr, o_value, o_pc, o_flags} !== {1'b0, 73'd0, m_flags}) begin
      errors++;
      $display("FAIL mul_flush_after: got stall=%b op=%h dr=%0d val=%h pc=%h fl=%b, required stall 0, zeros, fl=%b",
               o_pipe_stall, o_opcode, o_dr, o_value, o_pc, o_flags, m_flags);
    end
  endtask

  task automatic test_stall_hold();
    drive(OP_ADD, 4'd4, 32'd10, 32'd20, 0, 32'hA0);
    tick();
    i_pipe_stall = 1'b1;
    drive(OP_SUB, 4'd6, 32'd1, 32'd2, 0, 32'hA4);
    repeat (3) tick();
    checks++;
    if ({o_pipe_stall, o_opcode, o_dr, o_value, o_flags} !== {1'b1, OP_ADD, 4'd4, 32'd30, 4'b0000}) begin
      errors++;
      $display("FAIL stall_hold: got st=%b op=%h dr=%0d val=%h fl=%b, required 1 01 4 0000001e 0000",
               o_pipe_stall, o_opcode, o_dr, o_value, o_flags);
    end
    i_pipe_stall = 1'b0;
    tick();
    checks++;
    if ({o_opcode, o_dr, o_value, o_flags} !== {OP_SUB, 4'd6, 32'hFFFF_FFFF, 4'b0110}) begin
      errors++;
      $display("FAIL stall_release: got op=%h dr=%0d val=%h fl=%b, required 02 6 ffffffff 0110",
               o_opcode, o_dr, o_value, o_flags);
    end
    m_flags = 4'b0110;
    drive(OP_NOP, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    drive(OP_JMP, 4'd0, 32'h200, 0, 32'h4, 32'hB0);
    rst = 1'b1;
    #1;
    checks++;
    if ({o_branch_taken, o_pipe_flush} !== 2'b00) begin
      errors++;
      $display("FAIL reset_jmp: got taken=%b flush=%b, required 0 0", o_branch_taken, o_pipe_flush);
    end
    tick();
    rst = 1'b0;
    m_flags = '0;
    drive(OP_MUL, 4'd9, 32'd3, 32'd4, 0, 32'hB4);
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(OP_NOP, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({o_pipe_stall, o_pipe_flush, o_opcode, o_dr, o_value, o_pc, o_flags} !== '0) begin
      errors++;
      $display("FAIL reset_mul: got st=%b fl=%b op=%h dr=%0d val=%h pc=%h flags=%b, required all 0",
               o_pipe_stall, o_pipe_flush, o_opcode, o_dr, o_value, o_pc, o_flags);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_LW, OP_SW, OP_NOP};
    test_reset();
    test_add_overflow();
    test_jmp_taken();
    test_random_alu(60);
    test_random_jmp(40);
    test_mul(32'd7, 32'd6, 4'd5);
    test_mul_flush();
    test_mul($urandom, $urandom, 4'd11);
    test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15);
    test_stall_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
